// File: rtl/ifetch_unit.sv
// Instruction-fetch stage for the multi-cycle MIPS32 core: owns the PC, sequences the ROM read and loads IR.
// Optional build macro IFETCH_RANGE_CHK_EN adds an out-of-range / misaligned PC check with a sticky fetch_fault.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ROM disabled; accepts pc_wr updates and fetch_req
// S_REQ   | ROM enabled, address presented from the registered pc
// S_WAIT  | extra ROM access cycles, WAIT_CYCLES of them
// S_CAPT  | ROM data valid; IR loaded and pc advanced on the exit edge
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ROM_AW      = 9,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              fetch_req,
    input  logic              pc_wr,
    input  logic [1:0]        pc_src,
    input  logic [15:0]       br_offset,
    input  logic [25:0]       jmp_target,
    output logic              rom_nce,
    output logic              rom_re,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       ir,
    output logic [31:0]       pc,
    output logic              busy,
    output logic              fetch_done,
    output logic              fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_CAPT = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic [31:0] pc_upd, pc_nxt, ir_nxt;
    logic        done_nxt;
    logic        blocked;

    // pc update requested by decode/execute; only applied while idle
    always_comb begin
        pc_upd = pc;
        if (pc_wr) begin
            case (pc_src)
                2'b01:   pc_upd = pc + {{14{br_offset[15]}}, br_offset, 2'b00};
                2'b10:   pc_upd = {pc[31:28], jmp_target, 2'b00};
                default: pc_upd = pc;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pc_nxt       = pc;
        ir_nxt       = ir;
        done_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                pc_nxt = pc_upd;
                if (fetch_req) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (WAIT_CYCLES == 0) begin
                    state_nxt = S_CAPT;
                end else begin
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = WAIT_LD;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = S_CAPT;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            S_CAPT: begin
                state_nxt = S_IDLE;
                ir_nxt    = blocked ? 32'h0000_0000 : rom_data;
                pc_nxt    = pc + 32'd4;
                done_nxt  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            pc         <= RESET_PC;
            ir         <= 32'h0000_0000;
            fetch_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            pc         <= pc_nxt;
            ir         <= ir_nxt;
            fetch_done <= done_nxt;
        end
    end

`ifdef IFETCH_RANGE_CHK_EN
    function automatic logic addr_bad(input logic [31:0] a);
        return ((a >> (ROM_AW + 2)) != 32'd0) || (a[1:0] != 2'b00);
    endfunction

    // judged once on entry to S_REQ; pc cannot change until the fetch completes
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            blocked     <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (state == S_IDLE && fetch_req) begin
            blocked <= addr_bad(pc_upd);
            if (addr_bad(pc_upd)) fetch_fault <= 1'b1;
        end
    end
`else
    assign blocked     = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign busy     = (state != S_IDLE);
    assign rom_re   = busy;
    assign rom_nce  = !(busy && !blocked);
    assign rom_addr = pc[ROM_AW+1:2];

endmodule
